// File: rtl/location_tracker.sv
// Per-frame player location: bounding box over body-mask pixels, centroid over
// saber-mask pixels, snapshotted at nf_in and published after a shared divider.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | waiting for nf_in; outputs hold last published values
//   DIV_X   | 32 restoring-division steps of snapshot sum_x / saber_cnt
//   DIV_Y   | 32 restoring-division steps of snapshot sum_y / saber_cnt
//   PUBLISH | valid_out high for this one cycle, outputs just registered
module location_tracker #(
  parameter int MIN_BODY_PIXELS  = 64,
  parameter int MIN_SABER_PIXELS = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        pixel_valid_in,
  input  logic        body_mask_in,
  input  logic        saber_mask_in,
  input  logic        nf_in,
  output logic [11:0] rect_x_out,
  output logic [10:0] rect_y_out,
  output logic [10:0] rect_x_2_out,
  output logic [9:0]  rect_y_2_out,
  output logic [10:0] saber_x_out,
  output logic [9:0]  saber_y_out,
  output logic        body_found_out,
  output logic        saber_found_out,
  output logic        valid_out
);

  typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, PUBLISH} state_t;

  localparam logic [19:0] MIN_BODY_CNT  = 20'(MIN_BODY_PIXELS);
  localparam logic [19:0] MIN_SABER_CNT = 20'(MIN_SABER_PIXELS);

  // running accumulators
  logic [10:0] r_xmin, r_xmax;
  logic [9:0]  r_ymin, r_ymax;
  logic [19:0] r_body_cnt, r_saber_cnt;
  logic [30:0] r_sum_x;
  logic [29:0] r_sum_y;

  // frame snapshot
  logic [10:0] r_snap_xmin, r_snap_xmax;
  logic [9:0]  r_snap_ymin, r_snap_ymax;
  logic [19:0] r_snap_body_cnt, r_snap_saber_cnt;
  logic [29:0] r_snap_sum_y;

  // divider
  logic [31:0] r_div_q;
  logic [19:0] r_div_rem;
  logic [4:0]  r_iter;
  logic [10:0] r_quot_x;

  state_t r_state, w_state_nxt;
  logic   w_load_x, w_load_y, w_publish, w_div_step;

  logic        w_body_px, w_saber_px;
  logic [10:0] w_xmin_base, w_xmax_base;
  logic [9:0]  w_ymin_base, w_ymax_base;
  logic [19:0] w_body_cnt_base, w_saber_cnt_base;
  logic [30:0] w_sum_x_base;
  logic [29:0] w_sum_y_base;

  logic [20:0] w_trial;
  logic        w_ge;
  logic [19:0] w_rem_nxt;
  logic [31:0] w_q_nxt;
  logic [10:0] w_width;
  logic [9:0]  w_height;

  assign w_body_px  = pixel_valid_in & body_mask_in;
  assign w_saber_px = pixel_valid_in & saber_mask_in;

  // On nf_in the new frame starts from the initial values, so a coincident
  // pixel lands in the new frame rather than the snapshot.
  always_comb begin
    w_xmin_base      = r_xmin;
    w_xmax_base      = r_xmax;
    w_ymin_base      = r_ymin;
    w_ymax_base      = r_ymax;
    w_body_cnt_base  = r_body_cnt;
    w_saber_cnt_base = r_saber_cnt;
    w_sum_x_base     = r_sum_x;
    w_sum_y_base     = r_sum_y;
    if (nf_in) begin
      w_xmin_base      = 11'd2047;
      w_xmax_base      = 11'd0;
      w_ymin_base      = 10'd1023;
      w_ymax_base      = 10'd0;
      w_body_cnt_base  = 20'd0;
      w_saber_cnt_base = 20'd0;
      w_sum_x_base     = 31'd0;
      w_sum_y_base     = 30'd0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_xmin      <= 11'd2047;
      r_xmax      <= 11'd0;
      r_ymin      <= 10'd1023;
      r_ymax      <= 10'd0;
      r_body_cnt  <= 20'd0;
      r_saber_cnt <= 20'd0;
      r_sum_x     <= 31'd0;
      r_sum_y     <= 30'd0;
    end else begin
      r_xmin      <= (w_body_px && hcount_in < w_xmin_base) ? hcount_in : w_xmin_base;
      r_xmax      <= (w_body_px && hcount_in > w_xmax_base) ? hcount_in : w_xmax_base;
      r_ymin      <= (w_body_px && vcount_in < w_ymin_base) ? vcount_in : w_ymin_base;
      r_ymax      <= (w_body_px && vcount_in > w_ymax_base) ? vcount_in : w_ymax_base;
      r_body_cnt  <= w_body_px ? w_body_cnt_base + 20'd1 : w_body_cnt_base;
      r_saber_cnt <= w_saber_px ? w_saber_cnt_base + 20'd1 : w_saber_cnt_base;
      r_sum_x     <= w_saber_px ? w_sum_x_base + {20'd0, hcount_in} : w_sum_x_base;
      r_sum_y     <= w_saber_px ? w_sum_y_base + {20'd0, vcount_in} : w_sum_y_base;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_snap_xmin      <= 11'd0;
      r_snap_xmax      <= 11'd0;
      r_snap_ymin      <= 10'd0;
      r_snap_ymax      <= 10'd0;
      r_snap_body_cnt  <= 20'd0;
      r_snap_saber_cnt <= 20'd0;
      r_snap_sum_y     <= 30'd0;
    end else if (nf_in) begin
      r_snap_xmin      <= r_xmin;
      r_snap_xmax      <= r_xmax;
      r_snap_ymin      <= r_ymin;
      r_snap_ymax      <= r_ymax;
      r_snap_body_cnt  <= r_body_cnt;
      r_snap_saber_cnt <= r_saber_cnt;
      r_snap_sum_y     <= r_sum_y;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // nf_in always wins: it restarts division and suppresses a pending publish.
  always_comb begin
    w_state_nxt = r_state;
    w_load_x    = 1'b0;
    w_load_y    = 1'b0;
    w_publish   = 1'b0;
    w_div_step  = 1'b0;
    if (nf_in) begin
      w_state_nxt = DIV_X;
      w_load_x    = 1'b1;
    end else begin
      case (r_state)
        DIV_X: begin
          w_div_step = 1'b1;
          if (r_iter == 5'd31) begin
            w_state_nxt = DIV_Y;
            w_load_y    = 1'b1;
          end
        end
        DIV_Y: begin
          w_div_step = 1'b1;
          if (r_iter == 5'd31) begin
            w_state_nxt = PUBLISH;
            w_publish   = 1'b1;
          end
        end
        PUBLISH: w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // One restoring step; a zero divisor yields all-ones, never X.
  assign w_trial   = {r_div_rem, r_div_q[31]};
  assign w_ge      = (w_trial >= {1'b0, r_snap_saber_cnt});
  assign w_rem_nxt = w_ge ? 20'(w_trial - {1'b0, r_snap_saber_cnt}) : w_trial[19:0];
  assign w_q_nxt   = {r_div_q[30:0], w_ge};

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_div_q   <= 32'd0;
      r_div_rem <= 20'd0;
      r_iter    <= 5'd0;
      r_quot_x  <= 11'd0;
    end else if (w_load_x) begin
      r_div_q   <= {1'b0, r_sum_x};
      r_div_rem <= 20'd0;
      r_iter    <= 5'd0;
    end else if (w_load_y) begin
      r_quot_x  <= w_q_nxt[10:0];
      r_div_q   <= {2'b00, r_snap_sum_y};
      r_div_rem <= 20'd0;
      r_iter    <= 5'd0;
    end else if (w_div_step) begin
      r_div_q   <= w_q_nxt;
      r_div_rem <= w_rem_nxt;
      r_iter    <= r_iter + 5'd1;
    end
  end

  assign w_width  = r_snap_xmax - r_snap_xmin;
  assign w_height = r_snap_ymax - r_snap_ymin;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rect_x_out      <= 12'd0;
      rect_y_out      <= 11'd0;
      rect_x_2_out    <= 11'd0;
      rect_y_2_out    <= 10'd0;
      saber_x_out     <= 11'd0;
      saber_y_out     <= 10'd0;
      body_found_out  <= 1'b0;
      saber_found_out <= 1'b0;
      valid_out       <= 1'b0;
    end else begin
      valid_out <= w_publish;
      if (w_publish) begin
        if (r_snap_body_cnt >= MIN_BODY_CNT) begin
          rect_x_out     <= {1'b0, r_snap_xmin} + {1'b0, r_snap_xmax};
          rect_y_out     <= {1'b0, r_snap_ymin} + {1'b0, r_snap_ymax};
          rect_x_2_out   <= {1'b0, w_width[10:1]};
          rect_y_2_out   <= {1'b0, w_height[9:1]};
          body_found_out <= 1'b1;
        end else begin
          body_found_out <= 1'b0;
        end
        if (r_snap_saber_cnt >= MIN_SABER_CNT) begin
          saber_x_out     <= r_quot_x;
          saber_y_out     <= w_q_nxt[9:0];
          saber_found_out <= 1'b1;
        end else begin
          saber_found_out <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_location_tracker.sv
// Randomized + directed bench for location_tracker: frame statistics are pushed
// to a queue at nf_in and a monitor checks each valid_out against them.
module tb_location_tracker;
  localparam int MINB = 64;
  localparam int MINS = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        pv, bm, sm, nf;
  logic [11:0] rect_x;
  logic [10:0] rect_y, rect_x_2, saber_x;
  logic [9:0]  rect_y_2, saber_y;
  logic        body_found, saber_found, valid;

  always #5 clk = ~clk;

  location_tracker #(.MIN_BODY_PIXELS(MINB), .MIN_SABER_PIXELS(MINS)) dut (
    .clk_in(clk), .rst_in(rst_n), .hcount_in(hcount), .vcount_in(vcount),
    .pixel_valid_in(pv), .body_mask_in(bm), .saber_mask_in(sm), .nf_in(nf),
    .rect_x_out(rect_x), .rect_y_out(rect_y), .rect_x_2_out(rect_x_2),
    .rect_y_2_out(rect_y_2), .saber_x_out(saber_x), .saber_y_out(saber_y),
    .body_found_out(body_found), .saber_found_out(saber_found), .valid_out(valid)
  );

  typedef struct {
    int     xmin, xmax, ymin, ymax, bcnt, scnt, due;
    longint sx, sy;
  } snap_t;

  snap_t q[$];
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  // reference accumulators and last published values
  int     a_xmin, a_xmax, a_ymin, a_ymax, a_bcnt, a_scnt;
  longint a_sx, a_sy;
  int     m_rx, m_ry, m_rx2, m_ry2, m_sx, m_sy, m_bf, m_sf;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic acc_clear();
    a_xmin = 2047; a_xmax = 0; a_ymin = 1023; a_ymax = 0;
    a_bcnt = 0; a_scnt = 0; a_sx = 0; a_sy = 0;
  endtask

  task automatic model_zero();
    m_rx = 0; m_ry = 0; m_rx2 = 0; m_ry2 = 0; m_sx = 0; m_sy = 0; m_bf = 0; m_sf = 0;
  endtask

  task automatic drive(input bit v, input int x, input int y, input bit b, input bit s, input bit f);
    snap_t e;
    @(negedge clk);
    pv = v; hcount = 11'(x); vcount = 10'(y); bm = b; sm = s; nf = f;
    if (f) begin
      e.xmin = a_xmin; e.xmax = a_xmax; e.ymin = a_ymin; e.ymax = a_ymax;
      e.bcnt = a_bcnt; e.scnt = a_scnt; e.sx = a_sx; e.sy = a_sy;
      e.due = cyc + 65;
      // a frame still dividing is abandoned
      if (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
      q.push_back(e);
      acc_clear();
    end
    if (v && b) begin
      if (x < a_xmin) a_xmin = x;
      if (x > a_xmax) a_xmax = x;
      if (y < a_ymin) a_ymin = y;
      if (y > a_ymax) a_ymax = y;
      a_bcnt++;
    end
    if (v && s) begin
      a_sx += x; a_sy += y; a_scnt++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic block(input int x0, input int x1, input int y0, input int y1, input bit b, input bit s);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) drive(1, x, y, b, s, 0);
  endtask

  // monitor / scoreboard
  initial begin
    snap_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        check("reset_rect", {rect_x, rect_y}, 0);
        check("reset_half", {rect_x_2, rect_y_2}, 0);
        check("reset_saber", {saber_x, saber_y}, 0);
        check("reset_flags", {body_found, saber_found, valid}, 0);
      end else begin
        if (q.size() > 0 && cyc > q[0].due) begin
          compared++; mismatched++;
          $display("FAIL valid_timeout: actual none required valid at cycle %0d (now %0d)", q[0].due, cyc);
          void'(q.pop_front());
        end
        if (valid === 1'b1) begin
          if (q.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL unexpected_valid: actual 1 required 0 (cycle %0d)", cyc);
          end else begin
            e = q.pop_front();
            check("valid_latency", cyc, e.due);
            if (e.bcnt >= MINB) begin
              m_rx = e.xmin + e.xmax; m_ry = e.ymin + e.ymax;
              m_rx2 = (e.xmax - e.xmin) / 2; m_ry2 = (e.ymax - e.ymin) / 2;
              m_bf = 1;
            end else m_bf = 0;
            if (e.scnt >= MINS) begin
              m_sx = int'(e.sx / e.scnt); m_sy = int'(e.sy / e.scnt);
              m_sf = 1;
            end else m_sf = 0;
          end
        end else begin
          check("valid_low", valid, 0);
        end
        check("rect_x", rect_x, m_rx);
        check("rect_y", rect_y, m_ry);
        check("rect_x_2", rect_x_2, m_rx2);
        check("rect_y_2", rect_y_2, m_ry2);
        check("saber_xy", {saber_x, saber_y}, {m_sx[10:0], m_sy[9:0]});
        check("found", {body_found, saber_found}, {m_bf[0], m_sf[0]});
      end
    end
  end

  initial begin
    int x, y, len, n0;
    rst_n = 1'b1;
    pv = 0; bm = 0; sm = 0; nf = 0; hcount = 0; vcount = 0;
    acc_clear(); model_zero();
    #2 rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(5);

    // body 100x50 plus 4x4 saber
    block(200, 299, 300, 349, 1, 0);
    block(600, 603, 100, 103, 0, 1);
    drive(0, 0, 0, 0, 0, 1);
    idle(70);
    check("tp_rect_x", rect_x, 499);
    check("tp_rect_y", rect_y, 649);
    check("tp_rect_x_2", rect_x_2, 49);
    check("tp_rect_y_2", rect_y_2, 24);
    check("tp_saber_a", {saber_x, saber_y}, {11'd601, 10'd101});
    check("tp_found_a", {body_found, saber_found}, 2'b11);

    // saber at far corner, no body
    block(1276, 1279, 716, 719, 0, 1);
    drive(0, 0, 0, 0, 0, 1);
    idle(70);
    check("tp_saber_b", {saber_x, saber_y}, {11'd1277, 10'd717});
    check("tp_body_hold", rect_x, 499);
    check("tp_found_b", {body_found, saber_found}, 2'b01);

    // 10 body pixels, no saber: everything holds, both lost
    block(10, 19, 5, 5, 1, 0);
    drive(0, 0, 0, 0, 0, 1);
    idle(70);
    check("tp_lost_rect", {rect_x, rect_y}, {12'd499, 11'd649});
    check("tp_lost_saber", {saber_x, saber_y}, {11'd1277, 10'd717});
    check("tp_lost_flags", {body_found, saber_found}, 2'b00);

    // second nf 20 cycles after first: only the second frame publishes
    block(100, 199, 10, 10, 1, 1);
    drive(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 19; i++) drive(1, 700 + i, 20, 1, 1, 0);
    drive(0, 0, 0, 0, 0, 1);
    idle(70);
    check("tp_restart_found", {body_found, saber_found}, 2'b01);
    check("tp_restart_saber", saber_x, 709);

    // body pixel at (0,0) coincident with nf
    block(500, 599, 400, 400, 1, 0);
    drive(1, 0, 0, 1, 0, 1);
    idle(70);
    check("tp_coinc_excl", {rect_x, rect_y}, {12'd1099, 11'd800});
    block(800, 899, 600, 600, 1, 0);
    drive(0, 0, 0, 0, 0, 1);
    idle(70);
    check("tp_coinc_next", {rect_x, rect_y}, {12'd899, 11'd600});

    // reset at DIV_Y iteration 10
    block(300, 399, 200, 200, 1, 1);
    drive(0, 0, 0, 0, 0, 1);
    idle(43);
    #1 rst_n = 1'b0;
    q.delete(); acc_clear(); model_zero();
    #1;
    check("rst_async_out", {rect_x, saber_x, body_found, saber_found, valid}, 0);
    idle(3);
    rst_n = 1'b1;
    idle(80);
    block(900, 999, 650, 650, 1, 1);
    drive(0, 0, 0, 0, 0, 1);
    idle(70);
    check("tp_post_reset", {rect_x, saber_x, body_found, saber_found}, {12'd1899, 11'd949, 2'b11});

    // random frames, including nf exactly in the last DIV_Y cycle and in PUBLISH
    for (int f = 0; f < 24; f++) begin
      len = (f == 5) ? 63 : (f == 6) ? 64 : $urandom_range(10, 220);
      for (int i = 0; i < len; i++) begin
        n0 = $urandom_range(0, 15);
        x = (n0 == 0) ? 0 : (n0 == 1) ? 1279 : $urandom_range(0, 1279);
        y = (n0 == 2) ? 0 : (n0 == 3) ? 719 : $urandom_range(0, 719);
        drive(($urandom % 4) != 0, x, y, $urandom % 2, ($urandom % 3) == 0, 0);
      end
      drive(($urandom % 2) == 0, $urandom_range(0, 1279), $urandom_range(0, 719), 1, 1, 1);
    end
    idle(80);
    check("queue_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
